// File: rtl/mem_io_responder.sv
// Memory-mapped responder for a processor MEM stage: a word RAM plus
// switch, push-button and LED registers. Reads answer one cycle after
// acceptance; illegal requests raise a one-cycle err pulse instead.
module mem_io_responder #(
  parameter int RAM_WORDS = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] addr,
  input  logic [31:0] wr_data,
  output logic [31:0] rd_data,
  output logic        rd_valid,
  output logic        err,
  input  logic        button0,
  input  logic        button1,
  input  logic [9:0]  switches,
  output logic [31:0] LEDS
);

  localparam int AW = $clog2(RAM_WORDS);
  localparam logic [31:0] SW_ADDR  = 32'h0000_FFF0;
  localparam logic [31:0] BTN_ADDR = 32'h0000_FFF4;
  localparam logic [31:0] LED_ADDR = 32'h0000_FFF8;

  logic [31:0] mem [RAM_WORDS];

  logic [9:0]  sw_s1_q, sw_s2_q;
  logic [1:0]  btn_s1_q, btn_s2_q, btn_s3_q;
  logic [1:0]  btn_lat_q, btn_lat_d;
  logic [31:0] leds_q, leds_d;
  logic [31:0] rd_data_q, rd_data_d;
  logic        rd_valid_q, rd_valid_d;
  logic        err_q, err_d;

  logic          hit_ram, hit_sw, hit_btn, hit_led;
  logic          legal, rd_acc, wr_acc;
  logic [AW-1:0] ram_idx;
  logic [1:0]    btn_rise;

  // Decode the request: legal only with exactly one strobe, word alignment and a mapped address.
  always_comb begin
    hit_ram = (addr[31:AW+2] == '0);
    hit_sw  = (addr == SW_ADDR);
    hit_btn = (addr == BTN_ADDR);
    hit_led = (addr == LED_ADDR);
    ram_idx = addr[AW+1:2];
    legal   = (mem_read ^ mem_write) && (addr[1:0] == 2'b00) &&
              (hit_ram || hit_sw || hit_btn || hit_led);
    rd_acc  = legal && mem_read;
    wr_acc  = legal && mem_write;
  end

  // Next-state for response, error, LED and button latch registers.
  // Writes to the read-only SW and BTN locations are accepted but have no effect.
  always_comb begin
    rd_data_d  = rd_data_q;
    rd_valid_d = rd_acc;
    err_d      = (mem_read || mem_write) && !legal;
    leds_d     = leds_q;
    btn_rise   = btn_s2_q & ~btn_s3_q;
    btn_lat_d  = btn_lat_q;
    if (rd_acc) begin
      if (hit_ram)      rd_data_d = mem[ram_idx];
      else if (hit_sw)  rd_data_d = {22'b0, sw_s2_q};
      else if (hit_btn) rd_data_d = {30'b0, btn_lat_q};
      else              rd_data_d = leds_q;
    end
    if (wr_acc && hit_led) leds_d = wr_data;
    // A rising edge in the same cycle as a BTN read keeps its bit set.
    if (rd_acc && hit_btn) btn_lat_d = 2'b00;
    btn_lat_d = btn_lat_d | btn_rise;
  end

  // RAM write port; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (!rst && wr_acc && hit_ram) mem[ram_idx] <= wr_data;
  end

  // Synchronizers, button latch, LEDs and the registered response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sw_s1_q    <= '0;
      sw_s2_q    <= '0;
      btn_s1_q   <= '0;
      btn_s2_q   <= '0;
      btn_s3_q   <= '0;
      btn_lat_q  <= '0;
      leds_q     <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      sw_s1_q    <= switches;
      sw_s2_q    <= sw_s1_q;
      btn_s1_q   <= {button1, button0};
      btn_s2_q   <= btn_s1_q;
      btn_s3_q   <= btn_s2_q;
      btn_lat_q  <= btn_lat_d;
      leds_q     <= leds_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      err_q      <= err_d;
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign err      = err_q;
  assign LEDS     = leds_q;

endmodule

// File: tb/tb_mem_io_responder.sv
// Directed bench for mem_io_responder: RAM, LED, switch and button
// access, illegal requests and asynchronous reset behaviour.
module tb_mem_io_responder;

  logic        clk;
  logic        rst;
  logic        mem_read, mem_write;
  logic [31:0] addr, wr_data;
  logic [31:0] rd_data;
  logic        rd_valid, err;
  logic        button0, button1;
  logic [9:0]  switches;
  logic [31:0] LEDS;

  int checks = 0;
  int errors = 0;

  mem_io_responder #(.RAM_WORDS(256)) dut (
    .clk      (clk),
    .rst      (rst),
    .mem_read (mem_read),
    .mem_write(mem_write),
    .addr     (addr),
    .wr_data  (wr_data),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .err      (err),
    .button0  (button0),
    .button1  (button1),
    .switches (switches),
    .LEDS     (LEDS)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d);
    mem_read  = rd;
    mem_write = wr;
    addr      = a;
    wr_data   = d;
  endtask

  // Advance one rising edge and settle just after it.
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    button0 = 1'b0;
    button1 = 1'b0;
    switches = 10'h000;
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    check("reset_leds", LEDS, 32'h0);
    check("reset_rd_valid", {31'b0, rd_valid}, 32'h0);
    check("reset_err", {31'b0, err}, 32'h0);
    check("reset_rd_data", rd_data, 32'h0);

    // RAM write, then read-after-write on the next cycle
    rst = 1'b0;
    drive(1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF);
    cycle();
    check("ram_wr_no_valid", {31'b0, rd_valid}, 32'h0);
    check("ram_wr_no_err", {31'b0, err}, 32'h0);
    drive(1'b1, 1'b0, 32'h0000_0010, 32'h0);
    cycle();
    check("ram_raw_valid", {31'b0, rd_valid}, 32'h1);
    check("ram_raw_data", rd_data, 32'hDEAD_BEEF);
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    cycle();
    check("idle_valid_low", {31'b0, rd_valid}, 32'h0);
    check("idle_data_hold", rd_data, 32'hDEAD_BEEF);

    // Back-to-back reads
    drive(1'b0, 1'b1, 32'h0000_0014, 32'h1111_1111);
    cycle();
    drive(1'b0, 1'b1, 32'h0000_0018, 32'h2222_2222);
    cycle();
    drive(1'b0, 1'b1, 32'h0000_0000, 32'h0BAD_F00D);
    cycle();
    drive(1'b1, 1'b0, 32'h0000_0014, 32'h0);
    cycle();
    check("b2b_first_valid", {31'b0, rd_valid}, 32'h1);
    check("b2b_first_data", rd_data, 32'h1111_1111);
    drive(1'b1, 1'b0, 32'h0000_0018, 32'h0);
    cycle();
    check("b2b_second_valid", {31'b0, rd_valid}, 32'h1);
    check("b2b_second_data", rd_data, 32'h2222_2222);

    // LED write and read
    drive(1'b0, 1'b1, 32'h0000_FFF8, 32'h0000_00A5);
    cycle();
    check("led_write", LEDS, 32'h0000_00A5);
    check("led_write_no_valid", {31'b0, rd_valid}, 32'h0);
    drive(1'b1, 1'b0, 32'h0000_FFF8, 32'h0);
    cycle();
    check("led_read_valid", {31'b0, rd_valid}, 32'h1);
    check("led_read_data", rd_data, 32'h0000_00A5);

    // Switches through the synchronizer
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    switches = 10'h3FF;
    repeat (3) cycle();
    drive(1'b1, 1'b0, 32'h0000_FFF0, 32'h0);
    cycle();
    check("sw_read_valid", {31'b0, rd_valid}, 32'h1);
    check("sw_read_data", rd_data, 32'h0000_03FF);

    // button1 pulse, read-with-clear
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    button1 = 1'b1;
    repeat (3) cycle();
    button1 = 1'b0;
    drive(1'b1, 1'b0, 32'h0000_FFF4, 32'h0);
    cycle();
    check("btn1_first_read", rd_data, 32'h0000_0002);
    cycle();
    check("btn1_second_read", rd_data, 32'h0000_0000);

    // button0 rising edge lands on the same edge as a BTN read: set wins
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    button0 = 1'b1;
    repeat (2) cycle();
    drive(1'b1, 1'b0, 32'h0000_FFF4, 32'h0);
    cycle();
    check("btn0_coincident_read", rd_data, 32'h0000_0000);
    cycle();
    check("btn0_set_wins", rd_data, 32'h0000_0001);
    cycle();
    check("btn0_cleared", rd_data, 32'h0000_0000);

    // Illegal: misaligned read
    drive(1'b1, 1'b0, 32'h0000_0012, 32'h0);
    cycle();
    check("misaligned_err", {31'b0, err}, 32'h1);
    check("misaligned_no_valid", {31'b0, rd_valid}, 32'h0);
    check("misaligned_leds", LEDS, 32'h0000_00A5);
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    cycle();
    check("err_one_cycle", {31'b0, err}, 32'h0);

    // Illegal: unmapped write (would alias RAM word 0 if decoded loosely)
    drive(1'b0, 1'b1, 32'h0000_8000, 32'h5555_5555);
    cycle();
    check("unmapped_err", {31'b0, err}, 32'h1);
    check("unmapped_no_valid", {31'b0, rd_valid}, 32'h0);
    check("unmapped_leds", LEDS, 32'h0000_00A5);

    // Illegal: read and write together
    drive(1'b1, 1'b1, 32'h0000_FFF8, 32'h0000_0077);
    cycle();
    check("both_err", {31'b0, err}, 32'h1);
    check("both_no_valid", {31'b0, rd_valid}, 32'h0);
    check("both_leds", LEDS, 32'h0000_00A5);
    drive(1'b1, 1'b0, 32'h0000_0000, 32'h0);
    cycle();
    check("ram0_untouched", rd_data, 32'h0BAD_F00D);
    check("ram0_no_err", {31'b0, err}, 32'h0);

    // Set up LEDS=0xFF and btn_lat=1 ahead of reset
    drive(1'b0, 1'b1, 32'h0000_FFF8, 32'h0000_00FF);
    button0 = 1'b0;
    cycle();
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    repeat (3) cycle();
    button0 = 1'b1;
    repeat (3) cycle();
    button0 = 1'b0;
    repeat (3) cycle();
    check("pre_rst_leds", LEDS, 32'h0000_00FF);
    check("pre_rst_btn_lat", {30'b0, dut.btn_lat_q}, 32'h1);

    // Reset asserted mid-read, between edges
    drive(1'b1, 1'b0, 32'h0000_FFF4, 32'h0);
    cycle();
    check("pre_rst_read_valid", {31'b0, rd_valid}, 32'h1);
    #2;
    rst = 1'b1;
    #1;
    check("rst_leds", LEDS, 32'h0);
    check("rst_btn_lat", {30'b0, dut.btn_lat_q}, 32'h0);
    check("rst_rd_valid", {31'b0, rd_valid}, 32'h0);
    check("rst_rd_data", rd_data, 32'h0);
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    repeat (2) cycle();
    rst = 1'b0;
    cycle();
    check("post_rst_no_response", {31'b0, rd_valid}, 32'h0);
    check("post_rst_no_err", {31'b0, err}, 32'h0);

    // First request after release; RAM survives reset
    drive(1'b1, 1'b0, 32'h0000_0010, 32'h0);
    cycle();
    check("post_rst_ram_valid", {31'b0, rd_valid}, 32'h1);
    check("post_rst_ram_data", rd_data, 32'hDEAD_BEEF);
    drive(1'b1, 1'b0, 32'h0000_FFF4, 32'h0);
    cycle();
    check("post_rst_btn_clear", rd_data, 32'h0000_0000);
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_io_responder.md
MEM_IO_RESPONDER -- requirements
Module: mem_io_responder

Interface
REQ-001 Parameter RAM_WORDS, default 256, SHALL set the data RAM depth in 32-bit words (power of two, at most 256).
REQ-002 Port clk, input, 1, SHALL be the single clock; all state updates on its rising edge.
REQ-003 Port rst, input, 1, SHALL be an asynchronous, active-high reset.
REQ-004 Port mem_read, input, 1, SHALL be the processor MEM-stage read request, sampled each cycle.
REQ-005 Port mem_write, input, 1, SHALL be the processor MEM-stage write request, sampled each cycle.
REQ-006 Port addr, input, 32, SHALL be the byte address of the request.
REQ-007 Port wr_data, input, 32, SHALL be the write data.
REQ-008 Port rd_data, output, 32, SHALL be the registered read response.
REQ-009 Port rd_valid, output, 1, SHALL pulse for one cycle when rd_data holds a response.
REQ-010 Port err, output, 1, SHALL pulse for one cycle on an illegal request.
REQ-011 Port button0 and port button1, input, 1 each, SHALL be asynchronous push-button levels.
REQ-012 Port switches, input, 10, SHALL be asynchronous switch levels.
REQ-013 Port LEDS, output, 32, SHALL be the registered LED output.

Function
REQ-014 The address map SHALL be as follows:
- RAM at 0x0000_0000 to 4*RAM_WORDS-1, indexed by addr[9:2].
- SW at 0x0000_FFF0, read-only.
- BTN at 0x0000_FFF4, read with clear.
- LED at 0x0000_FFF8, read/write.
REQ-015 A request SHALL be legal only if exactly one of mem_read/mem_write is 1, addr[1:0]=0, and addr hits the map.
REQ-016 A request accepted at edge N SHALL produce rd_valid=1 and rd_data in the cycle after edge N, for reads only; the read latency is 1 cycle.
REQ-017 A legal write SHALL update its target at edge N, with no response and rd_valid=0.
REQ-018 A read issued the cycle after a write to the same address SHALL return the new data.
REQ-019 Back-to-back reads SHALL be accepted every cycle, one response per request, in order.
REQ-020 An SW read SHALL return {22'b0, switches after a 2-flop synchronizer}.
REQ-021 button0 and button1 SHALL each pass through a 2-flop synchronizer; a synchronized 0->1 transition SHALL set sticky bit btn_lat[0] or btn_lat[1] respectively.
REQ-022 A BTN read SHALL return {30'b0, btn_lat} and SHALL clear btn_lat at the same edge.
REQ-023 A new rising edge coinciding with a BTN read SHALL leave that bit set; set wins over clear.
REQ-024 An LED write SHALL load wr_data into LEDS; an LED read SHALL return LEDS.
REQ-025 On an illegal request, err SHALL pulse 1 in the following cycle and rd_valid SHALL stay 0. Illegal cases:
- misaligned address;
- unmapped address;
- mem_read=mem_write=1.
REQ-026 An illegal request SHALL modify no RAM, LED or btn_lat state.
REQ-027 rd_data SHALL hold its last value whenever rd_valid=0.
REQ-028 RAM SHALL be a single synchronous-write, synchronous-read array of RAM_WORDS x 32 bits.

Reset
REQ-029 Asserting rst SHALL immediately force the following to 0:
- LEDS, rd_data, rd_valid, err;
- btn_lat;
- all synchronizer flops.
REQ-030 RAM contents SHALL NOT be reset.
REQ-031 A request in flight when rst asserts SHALL be discarded, with no response after reset release.
REQ-032 The first request SHALL be accepted at the first rising edge after rst deasserts.

Verification
REQ-033 The bench SHALL cover: write 0xDEADBEEF to 0x0000_0010, then read 0x0000_0010 the next cycle -> rd_valid=1 one cycle later with rd_data=0xDEADBEEF.
REQ-034 The bench SHALL cover: write 0x0000_00A5 to 0x0000_FFF8 -> LEDS=0x0000_00A5 after the edge; a read of 0x0000_FFF8 -> rd_data=0x0000_00A5.
REQ-035 The bench SHALL cover: pulse button1 high for 3 cycles, then read 0x0000_FFF4 twice -> first rd_data=0x2, second rd_data=0x0.
REQ-036 The bench SHALL cover: switches=10'h3FF held for 3 cycles, then read 0x0000_FFF0 -> rd_data=0x0000_03FF.
REQ-037 The bench SHALL cover these illegal requests, each -> err=1 for one cycle, rd_valid=0, LEDS unchanged:
- read of 0x0000_0012;
- write to 0x0000_8000;
- mem_read=mem_write=1.
REQ-038 The bench SHALL cover: LEDS=0xFF and btn_lat=0x1, assert rst mid-read -> LEDS=0, btn_lat=0, rd_valid=0 immediately, and no response after release.
